// File: rtl/fpga_tick_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpga_tick_timer_sched
// Purpose  : Programmable tick prescaler shared by NUM_CH countdown channels,
//            with round-robin serialisation of expiries onto one event port.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_tick_timer_sched #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 250000,
    localparam int CH_W   = (NUM_CH > 4) ? 3 : 2
) (
    input  logic              clk25mhz,
    input  logic              reset_n,
    input  logic              cfg_div_we,
    input  logic [17:0]       cfg_div,
    output logic              tick,
    input  logic              arm_valid,
    output logic              arm_ready,
    input  logic [CH_W-1:0]   arm_ch,
    input  logic [CNT_W-1:0]  arm_count,
    input  logic              arm_periodic,
    output logic [NUM_CH-1:0] ch_active,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_overrun
);

    localparam logic [17:0] C_DIV_RST = 18'(DIV_RST);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [17:0]       r_pc;
    logic [17:0]       r_div_q;
    logic [17:0]       r_div_pend;
    logic              r_upd;
    logic              r_tick;
    logic              w_wrap;
    logic              w_arm_acc;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_evt_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_evt_valid;
    logic              w_hs_any;
    logic              w_load;
    logic              w_found;
    logic [CH_W-1:0]   w_ch_inc;
    logic [CH_W-1:0]   w_start;
    logic [CH_W-1:0]   w_sel;
    logic              w_ovr_sel;
    int                w_best;

    logic [NUM_CH-1:0] w_active;
    logic [NUM_CH-1:0] w_ovr;
    logic [NUM_CH-1:0] w_avail;

    // ------------------------------------------------------------------------
    // Prescaler: a new divisor only takes effect at a wrap, so the running
    // period always completes with the old value.
    // ------------------------------------------------------------------------
    assign w_wrap = (r_pc == (r_div_q - 18'd1));

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_div_q    <= C_DIV_RST;
            r_div_pend <= C_DIV_RST;
            r_upd      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_pc   <= w_wrap ? '0 : r_pc + 18'd1;
            if (w_wrap && r_upd) begin
                r_div_q <= r_div_pend;
            end
            if (cfg_div_we) begin
                r_div_pend <= (cfg_div < 18'd2) ? 18'd2 : cfg_div;
                r_upd      <= 1'b1;
            end else if (w_wrap) begin
                r_upd <= 1'b0;
            end
        end
    end

    assign tick      = r_tick;
    assign arm_ready = ~r_tick;
    assign w_arm_acc = arm_valid && !r_tick;

    assign r_evt_valid = (r_state == ST_PRESENT);
    assign w_hs_any    = r_evt_valid && evt_ready;
    assign w_ch_inc    = (int'(r_evt_ch) + 1 >= NUM_CH) ? '0 : r_evt_ch + CH_W'(1);

    // ------------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_rel;
        logic             r_per;
        logic             r_act;
        logic             r_pend;
        logic             r_ovr;
        logic             w_arm;
        logic             w_exp;
        logic             w_shown;
        logic             w_hs;

        assign w_arm   = w_arm_acc && (int'(arm_ch) == c);
        assign w_exp   = r_tick && r_act && (r_cnt == CNT_W'(1));
        assign w_shown = r_evt_valid && (int'(r_evt_ch) == c);
        assign w_hs    = w_shown && evt_ready;

        always_ff @(posedge clk25mhz or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_rel  <= '0;
                r_per  <= 1'b0;
                r_act  <= 1'b0;
                r_pend <= 1'b0;
                r_ovr  <= 1'b0;
            end else begin
                if (w_arm) begin
                    r_cnt <= arm_count;
                    r_rel <= arm_count;
                    r_per <= arm_periodic;
                    r_act <= (arm_count != '0);
                end else if (r_tick && r_act) begin
                    if (w_exp) begin
                        if (r_per) begin
                            r_cnt <= r_rel;
                        end else begin
                            r_cnt <= '0;
                            r_act <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                // A presented event is only ever retired by its handshake.
                if (w_exp) begin
                    if (r_pend && !w_hs) begin
                        r_ovr <= 1'b1;
                    end else begin
                        r_pend <= 1'b1;
                        if (w_hs) begin
                            r_ovr <= 1'b0;
                        end
                    end
                end else if (w_hs) begin
                    r_pend <= 1'b0;
                    r_ovr  <= 1'b0;
                end else if (w_arm) begin
                    r_ovr <= 1'b0;
                    if (!w_shown) begin
                        r_pend <= 1'b0;
                    end
                end
            end
        end

        assign w_active[c] = r_act;
        assign w_ovr[c]    = r_ovr;
        assign w_avail[c]  = r_pend && !w_hs && !(w_arm && !w_shown);
    end

    assign ch_active = w_active;

    // ------------------------------------------------------------------------
    // Round-robin pick: nearest available channel at or after the start point
    // ------------------------------------------------------------------------
    always_comb begin
        w_start = w_hs_any ? w_ch_inc : r_rr_ptr;
        w_sel   = '0;
        w_best  = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_avail[c] && (((c - int'(w_start) + NUM_CH) % NUM_CH) < w_best)) begin
                w_best = (c - int'(w_start) + NUM_CH) % NUM_CH;
                w_sel  = CH_W'(c);
            end
        end
        w_found = |w_avail;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_PRESENT;
                    w_load      = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_evt_ch <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_evt_ch <= w_sel;
            end
            if (w_hs_any) begin
                r_rr_ptr <= w_ch_inc;
            end
        end
    end

    always_comb begin
        w_ovr_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(r_evt_ch) == c) begin
                w_ovr_sel = w_ovr[c];
            end
        end
    end

    assign evt_valid   = r_evt_valid;
    assign evt_ch      = r_evt_ch;
    assign evt_overrun = r_evt_valid && w_ovr_sel;

endmodule
`default_nettype wire

// File: tb/tb_fpga_tick_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_tick_timer_sched
// Purpose  : Scenario tasks plus a randomized scoreboard for the tick timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_tick_timer_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int DIV    = 40;

    logic              clk25mhz = 1'b0;
    logic              reset_n  = 1'b0;
    logic              cfg_div_we = 1'b0;
    logic [17:0]       cfg_div = '0;
    logic              tick;
    logic              arm_valid = 1'b0;
    logic              arm_ready;
    logic [1:0]        arm_ch = '0;
    logic [CNT_W-1:0]  arm_count = '0;
    logic              arm_periodic = 1'b0;
    logic [NUM_CH-1:0] ch_active;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [1:0]        evt_ch;
    logic              evt_overrun;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int m_rr = 0;

    always #20 clk25mhz = ~clk25mhz;

    fpga_tick_timer_sched #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV)
    ) dut (
        .clk25mhz     (clk25mhz),
        .reset_n      (reset_n),
        .cfg_div_we   (cfg_div_we),
        .cfg_div      (cfg_div),
        .tick         (tick),
        .arm_valid    (arm_valid),
        .arm_ready    (arm_ready),
        .arm_ch       (arm_ch),
        .arm_count    (arm_count),
        .arm_periodic (arm_periodic),
        .ch_active    (ch_active),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_overrun  (evt_overrun)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk25mhz);
        #1;
        cyc++;
    endtask

    // Ends in the n-th tick cycle, counting the current cycle.
    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (1) begin
            if (tick === 1'b1) seen++;
            if (seen >= n) break;
            if (guard > n * 100) begin
                nvec++; nerr++;
                $display("FAIL tick_timeout: got %0d ticks expected %0d", seen, n);
                break;
            end
            step();
            guard++;
        end
    endtask

    task automatic arm(input int ch, input int cnt, input bit per);
        if (tick === 1'b1) step();
        arm_valid    = 1'b1;
        arm_ch       = 2'(ch);
        arm_count    = CNT_W'(cnt);
        arm_periodic = per;
        step();
        arm_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        nvec++;
        if ({tick, arm_ready, ch_active, evt_valid, evt_ch, evt_overrun} !== 10'b0_1_0000_0_00_0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {tick, arm_ready, ch_active, evt_valid, evt_ch, evt_overrun}, 10'b0_1_0000_0_00_0);
        end
        reset_n = 1'b1;
        cyc     = 0;
        while (1) begin
            nvec++;
            if (tick !== (cyc > 0 && cyc % DIV == 0)) begin
                nerr++;
                $display("FAIL reset_tick cyc %0d: got %b expected %b", cyc, tick, (cyc > 0 && cyc % DIV == 0));
            end
            if (cyc < DIV) begin
                nvec++;
                if (evt_valid !== 1'b0 || ch_active !== '0 || arm_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL reset_idle cyc %0d: got valid=%b active=%b ready=%b expected 0 0 1",
                             cyc, evt_valid, ch_active, arm_ready);
                end
            end
            if (cyc == 2 * DIV) break;
            step();
        end
    endtask

    task automatic test_divisor();
        int t0;
        int t1;
        int t2;
        int t3;
        t0 = cyc;
        repeat (5) step();
        cfg_div = 18'd10; cfg_div_we = 1'b1; step(); cfg_div_we = 1'b0;
        t1 = t0 + DIV;
        while (cyc < t1 + 40) begin
            nvec++;
            if (tick !== (cyc >= t1 && (cyc - t1) % 10 == 0)) begin
                nerr++;
                $display("FAIL div10 cyc %0d: got %b expected %b", cyc, tick, (cyc >= t1 && (cyc - t1) % 10 == 0));
            end
            step();
        end
        repeat (3) step();
        cfg_div = 18'd1; cfg_div_we = 1'b1; step(); cfg_div_we = 1'b0;
        t2 = t1 + 50;
        while (cyc < t2 + 10) begin
            nvec++;
            if (tick !== (cyc >= t2 && (cyc - t2) % 2 == 0)) begin
                nerr++;
                $display("FAIL div_clamp cyc %0d: got %b expected %b", cyc, tick, (cyc >= t2 && (cyc - t2) % 2 == 0));
            end
            step();
        end
        cfg_div = 18'd8; cfg_div_we = 1'b1; step(); cfg_div_we = 1'b0;
        t3 = t2 + 12;
        while (cyc < t3 + 24) begin
            nvec++;
            if (tick !== (cyc >= t3 && (cyc - t3) % 8 == 0)) begin
                nerr++;
                $display("FAIL div8 cyc %0d: got %b expected %b", cyc, tick, (cyc >= t3 && (cyc - t3) % 8 == 0));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b1;
        wait_ticks(1);
        step();
        for (int c = 0; c < NUM_CH; c++) arm(c, 1, 1'b0);
        wait_ticks(1);
        step();
        nvec++;
        if (evt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_early: got valid=%b expected 0", evt_valid);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            int exp_ch;
            exp_ch = (m_rr + k) % NUM_CH;
            step();
            nvec++;
            if (evt_valid !== 1'b1 || evt_ch !== 2'(exp_ch)) begin
                nerr++;
                $display("FAIL b2b_order slot %0d: got valid=%b ch=%0d expected valid=1 ch=%0d",
                         k, evt_valid, evt_ch, exp_ch);
            end
        end
        step();
        nvec++;
        if (evt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_drain: got valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_one_shot();
        evt_ready = 1'b0;
        wait_ticks(1);
        step();
        arm(1, 3, 1'b0);
        nvec++;
        if (ch_active[1] !== 1'b1) begin
            nerr++;
            $display("FAIL oneshot_active: got %b expected 1", ch_active[1]);
        end
        wait_ticks(3);
        step();
        nvec++;
        if (ch_active[1] !== 1'b0 || evt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL oneshot_t1: got active=%b valid=%b expected 0 0", ch_active[1], evt_valid);
        end
        step();
        nvec++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_overrun !== 1'b0) begin
            nerr++;
            $display("FAIL oneshot_evt: got valid=%b ch=%0d ovr=%b expected 1 1 0", evt_valid, evt_ch, evt_overrun);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        m_rr = 2;
        repeat (24) begin
            nvec++;
            if (evt_valid !== 1'b0 || ch_active !== '0) begin
                nerr++;
                $display("FAIL oneshot_quiet cyc %0d: got valid=%b active=%b expected 0 0", cyc, evt_valid, ch_active);
            end
            step();
        end
    endtask

    task automatic test_overrun();
        evt_ready = 1'b0;
        wait_ticks(1);
        step();
        arm(2, 1, 1'b1);
        wait_ticks(1);
        step(); step();
        nvec++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_overrun !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_first: got valid=%b ch=%0d ovr=%b expected 1 2 0", evt_valid, evt_ch, evt_overrun);
        end
        wait_ticks(1);
        step();
        nvec++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_overrun !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_second: got valid=%b ch=%0d ovr=%b expected 1 2 1", evt_valid, evt_ch, evt_overrun);
        end
        wait_ticks(1);
        step();
        nvec++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_overrun !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_third: got valid=%b ch=%0d ovr=%b expected 1 2 1", evt_valid, evt_ch, evt_overrun);
        end
        evt_ready = 1'b1;
        step();
        m_rr = 3;
        nvec++;
        if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_clear: got valid=%b ovr=%b expected 0 0", evt_valid, evt_overrun);
        end
        arm(2, 0, 1'b0);
        nvec++;
        if (ch_active[2] !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_disarm: got %b expected 0", ch_active[2]);
        end
        repeat (24) begin
            nvec++;
            if (evt_valid !== 1'b0) begin
                nerr++;
                $display("FAIL ovr_quiet cyc %0d: got valid=%b expected 0", cyc, evt_valid);
            end
            step();
        end
    endtask

    task automatic test_disarm();
        evt_ready = 1'b1;
        arm(3, 2, 1'b1);
        nvec++;
        if (ch_active[3] !== 1'b1) begin
            nerr++;
            $display("FAIL disarm_armed: got %b expected 1", ch_active[3]);
        end
        arm(3, 0, 1'b0);
        nvec++;
        if (ch_active !== '0) begin
            nerr++;
            $display("FAIL disarm_active: got %b expected 0000", ch_active);
        end
        repeat (30) begin
            nvec++;
            if (evt_valid !== 1'b0) begin
                nerr++;
                $display("FAIL disarm_quiet cyc %0d: got valid=%b expected 0", cyc, evt_valid);
            end
            step();
        end
    endtask

    task automatic test_tick_arm();
        wait_ticks(1);
        arm_valid = 1'b1; arm_ch = 2'd0; arm_count = CNT_W'(7); arm_periodic = 1'b0;
        nvec++;
        if (arm_ready !== 1'b0) begin
            nerr++;
            $display("FAIL tickarm_ready: got %b expected 0", arm_ready);
        end
        step();
        arm_valid = 1'b0;
        repeat (2) begin
            nvec++;
            if (ch_active !== '0) begin
                nerr++;
                $display("FAIL tickarm_effect: got %b expected 0000", ch_active);
            end
            step();
        end
    endtask

    task automatic test_random();
        int t_ref;
        bit m_act [NUM_CH];
        int m_left[NUM_CH];
        int m_owed[NUM_CH];
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = 1'b0; m_left[c] = 0; m_owed[c] = 0;
        end
        wait_ticks(1);
        t_ref = cyc;
        for (int i = 0; i < 700; i++) begin
            bit                p_tick;
            logic [NUM_CH-1:0] act_v;
            p_tick = ((cyc - t_ref) % 8) == 0;
            for (int c = 0; c < NUM_CH; c++) act_v[c] = m_act[c];
            nvec++;
            if (tick !== p_tick || arm_ready !== !p_tick) begin
                nerr++;
                $display("FAIL rand_tick cyc %0d: got tick=%b ready=%b expected %b %b", cyc, tick, arm_ready, p_tick, !p_tick);
            end
            nvec++;
            if (ch_active !== act_v) begin
                nerr++;
                $display("FAIL rand_active cyc %0d: got %b expected %b", cyc, ch_active, act_v);
            end
            if (p_tick) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_act[c]) begin
                        if (m_left[c] == 1) begin
                            m_act[c] = 1'b0;
                            m_owed[c]++;
                        end else begin
                            m_left[c]--;
                        end
                    end
                end
            end
            evt_ready = (i >= 600) || ($urandom_range(0, 3) != 0);
            if (evt_valid === 1'b1) begin
                nvec++;
                if (m_owed[evt_ch] == 0 || evt_overrun !== 1'b0) begin
                    nerr++;
                    $display("FAIL rand_event cyc %0d: got ch=%0d ovr=%b expected an expired channel with ovr=0",
                             cyc, evt_ch, evt_overrun);
                end else if (evt_ready) begin
                    m_owed[evt_ch]--;
                end
            end
            arm_valid = 1'b0;
            if (i < 600 && !p_tick && $urandom_range(0, 2) == 0) begin
                int c;
                int n;
                c = $urandom_range(0, NUM_CH - 1);
                n = $urandom_range(1, 3);
                if (!m_act[c] && m_owed[c] == 0) begin
                    arm_valid    = 1'b1;
                    arm_ch       = 2'(c);
                    arm_count    = CNT_W'(n);
                    arm_periodic = 1'b0;
                    m_act[c]     = 1'b1;
                    m_left[c]    = n;
                end
            end
            step();
        end
        arm_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            nvec++;
            if (m_owed[c] != 0 || m_act[c]) begin
                nerr++;
                $display("FAIL rand_drain ch %0d: got owed=%0d active=%b expected 0 0", c, m_owed[c], m_act[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        wait_ticks(1);
        step();
        arm(0, 1, 1'b0);
        wait_ticks(1);
        step(); step();
        nvec++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
            nerr++;
            $display("FAIL rstmid_pre: got valid=%b ch=%0d expected 1 0", evt_valid, evt_ch);
        end
        #5;
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({tick, arm_ready, ch_active, evt_valid, evt_ch, evt_overrun} !== 10'b0_1_0000_0_00_0) begin
            nerr++;
            $display("FAIL rstmid_async: got %b expected %b",
                     {tick, arm_ready, ch_active, evt_valid, evt_ch, evt_overrun}, 10'b0_1_0000_0_00_0);
        end
        @(posedge clk25mhz);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        while (cyc <= DIV) begin
            nvec++;
            if (tick !== (cyc == DIV) || evt_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rstmid_restart cyc %0d: got tick=%b valid=%b expected %b 0", cyc, tick, evt_valid, (cyc == DIV));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_back_to_back();
        test_one_shot();
        test_back_to_back();
        test_overrun();
        test_disarm();
        test_tick_arm();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpga_tick_timer_sched.md
# fpga_tick_timer_sched

Tick-based multi-channel timer scheduler for the V2M-MPS2 FPGA support logic. It divides clk25mhz into a programmable periodic tick, 100 Hz by default. It shares that tick among NUM_CH software or hardware countdown channels and serialises channel expiries onto a single valid/ready event port using round-robin arbitration. It sits beside the benchmarking clock logic and feeds the FPGA system interrupt/event logic.

## Interface
- NUM_CH, 4: number of timer channels. Legal 2..8. Width of arm_ch/evt_ch is CH_W = 3 when NUM_CH > 4, else 2.
- CNT_W, 16: channel count width, in ticks.
- DIV_RST, 250000: reset tick divisor in clk25mhz cycles (100 Hz).
- clk25mhz  in  1  sole clock, 25 MHz.
- reset_n  in  1  asynchronous active-low reset.
- cfg_div_we  in  1  single-cycle strobe; captures cfg_div.
- cfg_div  in  18  new tick divisor (cycles per tick).
- tick  out  1  one-cycle pulse per tick period.
- arm_valid  in  1  arm request.
- arm_ready  out  1  arm accepted when arm_valid && arm_ready.
- arm_ch  in  CH_W  target channel.
- arm_count  in  CNT_W  ticks to expiry; 0 = disarm.
- arm_periodic  in  1  1 = reload with arm_count after each expiry.
- ch_active  out  NUM_CH  channel running flags.
- evt_valid  out  1  expiry event presented.
- evt_ready  in  1  consumer accepts event.
- evt_ch  out  CH_W  channel of presented event.
- evt_overrun  out  1  at least one expiry of evt_ch was lost before this event was consumed.

## Operation
- Prescaler: 18-bit counter pc counts 0..div_q-1, then wraps to 0.
  - tick is registered and high for the one cycle after pc == div_q-1.
  - First tick occurs DIV_RST cycles after reset release.
- Divisor update: cfg_div_we loads div_pend (values < 2 clamp to 2) and sets upd.
  - div_q <= div_pend only on the wrap cycle, so the current period always completes.
  - A later write before the wrap overwrites div_pend.
- arm_ready = ~tick. Arms are not accepted on tick cycles.
- Accepted arm on channel c:
  - cnt[c] <= arm_count, rel[c] <= arm_count, per[c] <= arm_periodic, active[c] <= (arm_count != 0).
  - Clears ovr[c].
  - Clears pend[c] unless c is currently presented on evt (evt_valid && evt_ch == c).
  - arm_ch >= NUM_CH: accepted, no effect.
- On tick, for each active channel:
  - cnt > 1: cnt - 1.
  - cnt == 1: expiry. If per, cnt <= rel; else cnt <= 0 and active <= 0.
- Expiry on channel c:
  - If pend[c] is already 1 and not being consumed this cycle, set ovr[c]; otherwise set pend[c].
  - If handshake of c and expiry of c coincide: pend[c] stays 1 and ovr[c] is cleared.
- Event arbiter states: IDLE (evt_valid = 0) and PRESENT (evt_valid = 1).
  - IDLE -> PRESENT when any pend bit is set. Pick the first set bit at or after rr_ptr, wrapping.
  - PRESENT: evt_ch and evt_overrun are held stable while evt_ready = 0.
  - On handshake: pend[evt_ch] and ovr[evt_ch] clear, and rr_ptr <= evt_ch + 1 mod NUM_CH.
  - After handshake, next state is PRESENT if other bits are pending (back-to-back, no bubble), else IDLE.
- Reset mid-operation clears everything immediately, including a presented event (no handshake needed).

## Timing
- Reset values:
  - tick = 0, arm_ready = 1, ch_active = 0.
  - evt_valid = 0, evt_ch = 0, evt_overrun = 0.
  - pc = 0, div_q = DIV_RST, rr_ptr = 0, all cnt/rel/pend/ovr = 0.
- Arm to active: ch_active[c] is high the cycle after acceptance.
- Expiry latency: arm with count N completes on the N-th tick after acceptance.
  - pend is set the cycle after that tick.
  - evt_valid is high 2 cycles after that tick.
- Periodic channel: one expiry every N ticks exactly, with no drift across reloads.
- Arbiter throughput: one event per cycle with evt_ready held high.
- Clearing is always by handshake, never by an arm of a presented channel.
- Divisor change latency: effective from the first period starting after the current wrap.

## Test plan
- Reset, DIV_RST = 250000: first tick at cycle 250000, then every 250000. All outputs at reset values before that.
- cfg_div = 10 written mid-period: the old period completes, then ticks every 10 cycles. cfg_div = 1 gives a period of 2.
- Arm ch1 with count 3, one-shot: evt_valid with evt_ch = 1 two cycles after the 3rd tick; ch_active[1] drops after that tick; no further events.
- Arm ch0, ch1, ch2, ch3 all with count 1 and evt_ready = 1: events ch0, ch1, ch2, ch3 on consecutive cycles. Repeat with rr_ptr = 2: order is 2, 3, 0, 1.
- Periodic ch2 with count 1 and evt_ready = 0 for 3 ticks: evt_ch = 2 is held, then evt_overrun = 1. On handshake both clear.
- arm_valid on a tick cycle: arm_ready = 0 and no state change. Arm with count 0 on a running channel: ch_active clears next cycle and no event occurs. reset_n asserted while evt_valid = 1: evt_valid drops immediately.
